// File: rtl/csr_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// CSR addresses, mstatus/mie bit positions and the hardwired trap vector.
package csr_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_MRET = 2'd2,
    ST_WFI  = 2'd3
  } trap_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;

  localparam int unsigned MSTATUS_MIE_BIT  = 32'd3;
  localparam int unsigned MSTATUS_MPIE_BIT = 32'd7;
  localparam int unsigned MIE_MEIE_BIT     = 32'd11;

  // Must match the mtvec value hardwired in the CSR file.
  localparam logic [31:0] MTVEC_BASE_DEF = 32'h1000_0000;

endpackage

// File: rtl/csr_trap_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module csr_trap_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1'b1);

  // Count register; saturation blocks wrap-around to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: interrupt entry, MRET exit and WFI sleep/wake,
// driving the hardware write path of the CSR file with registered strobes.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] MTVEC_BASE = DATA_W'(MTVEC_BASE_DEF),
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt,
  input  logic              mstatus_mie,
  input  logic              mstatus_mpie,
  input  logic              mie_meie,
  input  logic [DATA_W-1:0] csr_mepc,
  input  logic [DATA_W-1:0] pc_exe,
  input  logic              exe_valid,
  input  logic              mret_valid,
  input  logic              wfi_valid,
  input  logic              stall,
  output logic              flush,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              mepc_we,
  output logic [DATA_W-1:0] mepc_wdata,
  output logic              mstatus_trap_we,
  output logic              mstatus_mret_we,
  output logic              wfi_stall,
  output logic [CNT_W-1:0]  irq_taken_cnt
);

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(32'd4);

  trap_state_t       state_r;
  trap_state_t       next_state_s;
  logic [DATA_W-1:0] next_latch_s;
  logic              irq_en_s;
  logic              wake_s;
  logic              cnt_inc_s;

  // mpie and the CSR map are owned by the CSR file; kept here only for context.
  logic unused_ctx_s;
  assign unused_ctx_s = ^{mstatus_mpie, CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC,
                          MSTATUS_MIE_BIT, MSTATUS_MPIE_BIT, MIE_MEIE_BIT};

  assign irq_en_s  = interrupt & mie_meie & mstatus_mie;
  assign wake_s    = interrupt & mie_meie;
  assign cnt_inc_s = (state_r == ST_TRAP) & ~stall;

  // Next-state and mepc-latch selection; IDLE priority is irq > mret > wfi.
  always_comb begin
    next_state_s = state_r;
    next_latch_s = mepc_wdata;
    case (state_r)
      ST_IDLE: begin
        if (stall) begin
          next_state_s = ST_IDLE;
        end else if (irq_en_s && exe_valid) begin
          next_state_s = ST_TRAP;
          next_latch_s = pc_exe;
        end else if (irq_en_s) begin
          // Wait for real code in EXE so mepc never points at a bubble.
          next_state_s = ST_IDLE;
        end else if (mret_valid) begin
          next_state_s = ST_MRET;
        end else if (wfi_valid) begin
          next_state_s = ST_WFI;
          next_latch_s = pc_exe + PC_STEP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_TRAP: begin
        if (stall) begin
          next_state_s = ST_TRAP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MRET: begin
        if (stall) begin
          next_state_s = ST_MRET;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WFI: begin
        if (wake_s && mstatus_mie) begin
          next_state_s = ST_TRAP;
        end else if (wake_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WFI;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, mepc latch and output registers; outputs mirror the state they enter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      mepc_wdata      <= {DATA_W{1'b0}};
      flush           <= 1'b0;
      redirect        <= 1'b0;
      redirect_pc     <= {DATA_W{1'b0}};
      mepc_we         <= 1'b0;
      mstatus_trap_we <= 1'b0;
      mstatus_mret_we <= 1'b0;
      wfi_stall       <= 1'b0;
    end else begin
      state_r         <= next_state_s;
      mepc_wdata      <= next_latch_s;
      flush           <= (next_state_s == ST_TRAP) || (next_state_s == ST_MRET);
      redirect        <= (next_state_s == ST_TRAP) || (next_state_s == ST_MRET);
      mepc_we         <= (next_state_s == ST_TRAP);
      mstatus_trap_we <= (next_state_s == ST_TRAP);
      mstatus_mret_we <= (next_state_s == ST_MRET);
      wfi_stall       <= (next_state_s == ST_WFI);
      case (next_state_s)
        ST_TRAP: redirect_pc <= MTVEC_BASE;
        ST_MRET: redirect_pc <= csr_mepc;
        default: redirect_pc <= {DATA_W{1'b0}};
      endcase
    end
  end

  csr_trap_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_irq_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc_s),
    .count (irq_taken_cnt)
  );

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed self-checking bench for csr_trap_ctrl; a second instance with a
// 2-bit counter observes the same stimulus to exercise counter saturation.
module tb_csr_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        interrupt;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_meie;
  logic [31:0] csr_mepc;
  logic [31:0] pc_exe;
  logic        exe_valid;
  logic        mret_valid;
  logic        wfi_valid;
  logic        stall;

  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mepc_we;
  logic [31:0] mepc_wdata;
  logic        mstatus_trap_we;
  logic        mstatus_mret_we;
  logic        wfi_stall;
  logic [15:0] irq_taken_cnt;

  logic        unused_flush;
  logic        unused_redirect;
  logic [31:0] unused_redirect_pc;
  logic        unused_mepc_we;
  logic [31:0] unused_mepc_wdata;
  logic        unused_trap_we;
  logic        unused_mret_we;
  logic        unused_wfi_stall;
  logic [1:0]  sat_cnt;

  logic [5:0]  strobes;
  int          checks;
  int          errors;

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_TRAP = 6'b111100;
  localparam logic [5:0] S_MRET = 6'b110010;
  localparam logic [5:0] S_WFI  = 6'b000001;

  assign strobes = {flush, redirect, mepc_we, mstatus_trap_we, mstatus_mret_we, wfi_stall};

  csr_trap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .interrupt       (interrupt),
    .mstatus_mie     (mstatus_mie),
    .mstatus_mpie    (mstatus_mpie),
    .mie_meie        (mie_meie),
    .csr_mepc        (csr_mepc),
    .pc_exe          (pc_exe),
    .exe_valid       (exe_valid),
    .mret_valid      (mret_valid),
    .wfi_valid       (wfi_valid),
    .stall           (stall),
    .flush           (flush),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .mepc_we         (mepc_we),
    .mepc_wdata      (mepc_wdata),
    .mstatus_trap_we (mstatus_trap_we),
    .mstatus_mret_we (mstatus_mret_we),
    .wfi_stall       (wfi_stall),
    .irq_taken_cnt   (irq_taken_cnt)
  );

  csr_trap_ctrl #(.CNT_W(2)) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .interrupt       (interrupt),
    .mstatus_mie     (mstatus_mie),
    .mstatus_mpie    (mstatus_mpie),
    .mie_meie        (mie_meie),
    .csr_mepc        (csr_mepc),
    .pc_exe          (pc_exe),
    .exe_valid       (exe_valid),
    .mret_valid      (mret_valid),
    .wfi_valid       (wfi_valid),
    .stall           (stall),
    .flush           (unused_flush),
    .redirect        (unused_redirect),
    .redirect_pc     (unused_redirect_pc),
    .mepc_we         (unused_mepc_we),
    .mepc_wdata      (unused_mepc_wdata),
    .mstatus_trap_we (unused_trap_we),
    .mstatus_mret_we (unused_mret_we),
    .wfi_stall       (unused_wfi_stall),
    .irq_taken_cnt   (sat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    interrupt = 1'b0; mstatus_mie = 1'b0; mstatus_mpie = 1'b0; mie_meie = 1'b0;
    csr_mepc = 32'h0; pc_exe = 32'h0; exe_valid = 1'b0; mret_valid = 1'b0;
    wfi_valid = 1'b0; stall = 1'b0;

    // Reset state
    tick();
    chk("rst_strobes", {26'd0, strobes}, {26'd0, S_IDLE});
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_mepc_wdata", mepc_wdata, 32'h0);
    chk("rst_cnt", {16'd0, irq_taken_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Plain interrupt entry
    mstatus_mie = 1'b1; mie_meie = 1'b1; interrupt = 1'b1; exe_valid = 1'b1; pc_exe = 32'h100;
    tick();
    chk("t1_strobes", {26'd0, strobes}, {26'd0, S_TRAP});
    chk("t1_redirect_pc", redirect_pc, 32'h1000_0000);
    chk("t1_mepc_wdata", mepc_wdata, 32'h100);
    chk("t1_cnt_pre", {16'd0, irq_taken_cnt}, 32'd0);
    mstatus_mie = 1'b0; interrupt = 1'b0;
    tick();
    chk("t1_idle", {26'd0, strobes}, {26'd0, S_IDLE});
    chk("t1_cnt", {16'd0, irq_taken_cnt}, 32'd1);

    // Interrupt entry held by 3 stall cycles
    mstatus_mie = 1'b1; interrupt = 1'b1; pc_exe = 32'h180;
    tick();
    chk("t2_enter", {26'd0, strobes}, {26'd0, S_TRAP});
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_strobes", {26'd0, strobes}, {26'd0, S_TRAP});
      chk("t2_hold_pc", redirect_pc, 32'h1000_0000);
      chk("t2_hold_mepc", mepc_wdata, 32'h180);
      chk("t2_hold_cnt", {16'd0, irq_taken_cnt}, 32'd1);
    end
    stall = 1'b0; mstatus_mie = 1'b0; interrupt = 1'b0;
    tick();
    chk("t2_idle", {26'd0, strobes}, {26'd0, S_IDLE});
    chk("t2_cnt", {16'd0, irq_taken_cnt}, 32'd2);

    // MRET exit
    csr_mepc = 32'h200; mret_valid = 1'b1; pc_exe = 32'h1000_0040;
    tick();
    chk("t3_strobes", {26'd0, strobes}, {26'd0, S_MRET});
    chk("t3_redirect_pc", redirect_pc, 32'h200);
    mret_valid = 1'b0;
    tick();
    chk("t3_idle", {26'd0, strobes}, {26'd0, S_IDLE});

    // WFI with MIE=0: wake without a trap
    pc_exe = 32'h300; wfi_valid = 1'b1;
    tick();
    wfi_valid = 1'b0; exe_valid = 1'b0;
    chk("t4_wfi_enter", {26'd0, strobes}, {26'd0, S_WFI});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_sleep", {26'd0, strobes}, {26'd0, S_WFI});
    end
    interrupt = 1'b1;
    tick();
    chk("t4_wake_idle", {26'd0, strobes}, {26'd0, S_IDLE});
    chk("t4_cnt", {16'd0, irq_taken_cnt}, 32'd2);
    interrupt = 1'b0;
    tick();
    chk("t4_no_mepc_we", {31'd0, mepc_we}, 32'd0);

    // WFI with MIE=1: wake into a trap at WFI PC + 4
    mstatus_mie = 1'b1; exe_valid = 1'b1; wfi_valid = 1'b1; pc_exe = 32'h300;
    tick();
    wfi_valid = 1'b0; exe_valid = 1'b0;
    chk("t5_wfi_enter", {26'd0, strobes}, {26'd0, S_WFI});
    tick();
    interrupt = 1'b1;
    tick();
    chk("t5_trap", {26'd0, strobes}, {26'd0, S_TRAP});
    chk("t5_mepc_wdata", mepc_wdata, 32'h304);
    chk("t5_redirect_pc", redirect_pc, 32'h1000_0000);
    mstatus_mie = 1'b0; interrupt = 1'b0;
    tick();
    chk("t5_cnt", {16'd0, irq_taken_cnt}, 32'd3);
    chk("t5_sat_cnt", {30'd0, sat_cnt}, 32'd3);

    // Pending interrupt with a bubble in EXE, withdrawn before entry
    mstatus_mie = 1'b1; interrupt = 1'b1; exe_valid = 1'b0;
    tick();
    chk("t6_bubble_wait", {26'd0, strobes}, {26'd0, S_IDLE});
    tick();
    interrupt = 1'b0; exe_valid = 1'b1; pc_exe = 32'h340;
    tick();
    chk("t6_no_trap", {26'd0, strobes}, {26'd0, S_IDLE});
    chk("t6_cnt", {16'd0, irq_taken_cnt}, 32'd3);

    // Interrupt and MRET together: trap wins, saturated counter stays put
    interrupt = 1'b1; mret_valid = 1'b1; pc_exe = 32'h400; csr_mepc = 32'h200;
    tick();
    chk("t7_trap", {26'd0, strobes}, {26'd0, S_TRAP});
    chk("t7_redirect_pc", redirect_pc, 32'h1000_0000);
    chk("t7_mepc_wdata", mepc_wdata, 32'h400);
    mret_valid = 1'b0; interrupt = 1'b0; mstatus_mie = 1'b0;
    tick();
    chk("t7_idle", {26'd0, strobes}, {26'd0, S_IDLE});
    chk("t7_cnt", {16'd0, irq_taken_cnt}, 32'd4);
    chk("t7_sat_cnt", {30'd0, sat_cnt}, 32'd3);

    // Asynchronous reset in the middle of a trap
    mstatus_mie = 1'b1; interrupt = 1'b1; pc_exe = 32'h500;
    tick();
    chk("t8_trap", {26'd0, strobes}, {26'd0, S_TRAP});
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t8_async_strobes", {26'd0, strobes}, {26'd0, S_IDLE});
    chk("t8_async_pc", redirect_pc, 32'h0);
    chk("t8_async_mepc", mepc_wdata, 32'h0);
    chk("t8_async_cnt", {16'd0, irq_taken_cnt}, 32'd0);
    stall = 1'b0; interrupt = 1'b0; mstatus_mie = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t8_post_rst", {26'd0, strobes}, {26'd0, S_IDLE});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
